// File: rtl/fifo_to_axis_mux.sv
// Multi-queue egress stage: drains NUM_QUEUES FWFT FIFO heads onto one AXI4-Stream master,
// one whole packet at a time, round-robin between queues.
// Latency: one grant cycle, then one cycle from FIFO head to the registered AXIS output.
// Full rate inside a packet, one bubble between packets.
// Backpressure: a stalled m_tready holds the output register and suppresses q_rd.
// Ports: clk/reset (sync, active-high); enable gates new grants; q_empty/q_dout/q_rd form the
//        per-queue FWFT read ports; m_t* is the AXIS master; word_cnt/pkt_cnt count accepted
//        beats/packets; err_short flags a non-last beat with a partial strobe (sticky).
module fifo_to_axis_mux #(
    parameter int TDATA_BYTES = 32,
    parameter int CNT_W       = 5,
    parameter int SRC_W       = 16,
    parameter int TUSER_WIDTH = 128,
    parameter int TID_WIDTH   = 4,
    parameter int TDEST_WIDTH = 4,
    parameter int NUM_QUEUES  = 4,
    parameter int QID_W       = 2,
    localparam int ENTRY_W    = SRC_W + 8*TDATA_BYTES + CNT_W + 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [NUM_QUEUES-1:0]         q_empty,
    input  logic [NUM_QUEUES*ENTRY_W-1:0] q_dout,
    output logic [NUM_QUEUES-1:0]         q_rd,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic [8*TDATA_BYTES-1:0]      m_tdata,
    output logic [TDATA_BYTES-1:0]        m_tstrb,
    output logic                          m_tlast,
    output logic [TID_WIDTH-1:0]          m_tid,
    output logic [TDEST_WIDTH-1:0]        m_tdest,
    output logic [TUSER_WIDTH-1:0]        m_tuser,
    output logic [31:0]                   word_cnt,
    output logic [31:0]                   pkt_cnt,
    output logic                          err_short
);

    typedef enum logic {S_IDLE, S_XFER} state_t;

    state_t                   state_q, state_d;
    logic [QID_W-1:0]         grant_q, grant_d;
    logic [QID_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic                     tvalid_q, tvalid_d;
    logic [8*TDATA_BYTES-1:0] tdata_q, tdata_d;
    logic [TDATA_BYTES-1:0]   tstrb_q, tstrb_d;
    logic                     tlast_q, tlast_d;
    logic [TDEST_WIDTH-1:0]   tdest_q, tdest_d;
    logic [SRC_W-1:0]         src_q, src_d;
    logic [31:0]              word_cnt_q, word_cnt_d;
    logic [31:0]              pkt_cnt_q, pkt_cnt_d;
    logic                     err_short_q, err_short_d;

    logic [ENTRY_W-1:0]       head;
    logic                     head_last;
    logic [CNT_W-1:0]         head_cnt;
    logic [TDATA_BYTES-1:0]   head_strb;
    logic                     hs;
    logic                     load;
    logic                     found;
    int                       arb_idx;

    // Head of the granted queue, split into its fields.
    always_comb begin
        head      = q_dout[int'(grant_q)*ENTRY_W +: ENTRY_W];
        head_last = head[0];
        head_cnt  = head[CNT_W:1];
        head_strb = '0;
        for (int j = 0; j < TDATA_BYTES; j++) begin
            head_strb[j] = (j <= int'(head_cnt));
        end
    end

    assign hs   = tvalid_q && m_tready;
    // The output register may take a new beat when it is empty or being drained this cycle.
    assign load = (state_q == S_XFER) && !q_empty[grant_q] && (!tvalid_q || m_tready);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        tvalid_d    = tvalid_q;
        tdata_d     = tdata_q;
        tstrb_d     = tstrb_q;
        tlast_d     = tlast_q;
        tdest_d     = tdest_q;
        src_d       = src_q;
        err_short_d = err_short_q;
        q_rd        = '0;
        found       = 1'b0;
        arb_idx     = 0;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    // Search starts one past the last winner so every queue gets a turn.
                    for (int i = 1; i <= NUM_QUEUES; i++) begin
                        arb_idx = (int'(rr_ptr_q) + i) % NUM_QUEUES;
                        if (!found && !q_empty[arb_idx]) begin
                            found   = 1'b1;
                            grant_d = QID_W'(arb_idx);
                        end
                    end
                    if (found) begin
                        rr_ptr_d = grant_d;
                        state_d  = S_XFER;
                    end
                end
            end
            S_XFER: begin
                if (load) begin
                    q_rd[grant_q] = 1'b1;
                    if (head_last) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            tvalid_d = 1'b1;
            tdata_d  = head[CNT_W+1 +: 8*TDATA_BYTES];
            tstrb_d  = head_strb;
            tlast_d  = head_last;
            tdest_d  = TDEST_WIDTH'(grant_q);
            src_d    = head[ENTRY_W-1 -: SRC_W];
            if (!head_last && (head_cnt != CNT_W'(TDATA_BYTES-1))) begin
                err_short_d = 1'b1;
            end
        end else if (m_tready) begin
            tvalid_d = 1'b0;
        end

        word_cnt_d = word_cnt_q + 32'(hs);
        pkt_cnt_d  = pkt_cnt_q + 32'(hs && tlast_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= QID_W'(NUM_QUEUES-1);
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tstrb_q     <= '0;
            tlast_q     <= 1'b0;
            tdest_q     <= '0;
            src_q       <= '0;
            word_cnt_q  <= '0;
            pkt_cnt_q   <= '0;
            err_short_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
            tstrb_q     <= tstrb_d;
            tlast_q     <= tlast_d;
            tdest_q     <= tdest_d;
            src_q       <= src_d;
            word_cnt_q  <= word_cnt_d;
            pkt_cnt_q   <= pkt_cnt_d;
            err_short_q <= err_short_d;
        end
    end

    assign m_tvalid  = tvalid_q;
    assign m_tdata   = tdata_q;
    assign m_tstrb   = tstrb_q;
    assign m_tlast   = tlast_q;
    assign m_tid     = '0;
    assign m_tdest   = tdest_q;
    assign m_tuser   = TUSER_WIDTH'(src_q);
    assign word_cnt  = word_cnt_q;
    assign pkt_cnt   = pkt_cnt_q;
    assign err_short = err_short_q;

endmodule

// File: tb/tb_fifo_to_axis_mux.sv
// Bench for fifo_to_axis_mux: FWFT queue models feed the DUT, a monitor records accepted beats,
// table vectors and directed sequences compare them against hand-computed expectations.
// Backpressure is driven directly on m_tready.
module tb_fifo_to_axis_mux;

    localparam int NQ = 4;
    localparam int EW = 16 + 256 + 5 + 1;

    typedef logic [EW-1:0] entry_t;

    typedef struct {
        int          q;
        logic [15:0] src;
        logic [31:0] k;
        logic [4:0]  cnt;
        logic        last;
        logic [31:0] exp_strb;
        logic [3:0]  exp_dest;
        int          exp_gap;
    } vec_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic [NQ-1:0]      q_empty;
    logic [NQ*EW-1:0]   q_dout;
    logic [NQ-1:0]      q_rd;
    logic               m_tvalid;
    logic               m_tready;
    logic [255:0]       m_tdata;
    logic [31:0]        m_tstrb;
    logic               m_tlast;
    logic [3:0]         m_tid;
    logic [3:0]         m_tdest;
    logic [127:0]       m_tuser;
    logic [31:0]        word_cnt;
    logic [31:0]        pkt_cnt;
    logic               err_short;

    fifo_to_axis_mux dut (
        .clk(clk), .reset(reset), .enable(enable),
        .q_empty(q_empty), .q_dout(q_dout), .q_rd(q_rd),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tstrb(m_tstrb), .m_tlast(m_tlast), .m_tid(m_tid),
        .m_tdest(m_tdest), .m_tuser(m_tuser),
        .word_cnt(word_cnt), .pkt_cnt(pkt_cnt), .err_short(err_short)
    );

    always #5 clk = ~clk;

    // FWFT queue models
    entry_t mem [NQ][32];
    int     wr_ptr [NQ] = '{default: 0};
    int     rd_ptr [NQ] = '{default: 0};

    always_comb begin
        q_empty = '0;
        q_dout  = '0;
        for (int i = 0; i < NQ; i++) begin
            q_empty[i]           = (wr_ptr[i] == rd_ptr[i]);
            q_dout[i*EW +: EW]   = mem[i][rd_ptr[i] % 32];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NQ; i++) begin
            if (q_rd[i]) rd_ptr[i] <= rd_ptr[i] + 1;
        end
    end

    // Beat monitor
    int           cyc = 0;
    int           cap_n = 0;
    logic [255:0] cap_dat  [64];
    logic [31:0]  cap_strb [64];
    logic         cap_last [64];
    logic [3:0]   cap_dest [64];
    logic [127:0] cap_user [64];
    int           cap_cyc  [64];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset && m_tvalid && m_tready && cap_n < 64) begin
            cap_dat[cap_n]  = m_tdata;
            cap_strb[cap_n] = m_tstrb;
            cap_last[cap_n] = m_tlast;
            cap_dest[cap_n] = m_tdest;
            cap_user[cap_n] = m_tuser;
            cap_cyc[cap_n]  = cyc;
            cap_n = cap_n + 1;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic entry_t mk(input logic [15:0] src, input logic [31:0] k,
                                  input logic [4:0] cnt, input logic last);
        return {src, {8{k}}, cnt, last};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int q, input entry_t e);
        mem[q][wr_ptr[q] % 32] = e;
        wr_ptr[q] = wr_ptr[q] + 1;
    endtask

    task automatic wait_caps(input int n);
        int b = 0;
        while (cap_n < n && b < 200) begin
            step();
            b++;
        end
        chk("wait_beats", cap_n, n);
    endtask

    task automatic wait_valid();
        int b = 0;
        while (!m_tvalid && b < 50) begin
            step();
            b++;
        end
        chk("wait_valid", m_tvalid, 1'b1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Compare a captured beat against an expected queue/entry.
    task automatic chk_beat(input string name, input int idx, input logic [31:0] k,
                            input logic [31:0] strb, input logic last, input logic [3:0] dest);
        logic [255:0] d;
        d = {8{k}};
        chk({name, "_data"}, cap_dat[idx], d);
        chk({name, "_ctl"}, {cap_strb[idx], cap_last[idx], cap_dest[idx]}, {strb, last, dest});
    endtask

    vec_t tbl [11];

    task automatic run_group(input int lo, input int hi);
        int start;
        start = cap_n;
        for (int i = lo; i <= hi; i++) begin
            push(tbl[i].q, mk(tbl[i].src, tbl[i].k, tbl[i].cnt, tbl[i].last));
        end
        wait_caps(start + hi - lo + 1);
        for (int i = lo; i <= hi; i++) begin
            int c;
            c = start + i - lo;
            chk("vec_data", cap_dat[c], {8{tbl[i].k}});
            chk("vec_strb", cap_strb[c], tbl[i].exp_strb);
            chk("vec_last", cap_last[c], tbl[i].last);
            chk("vec_dest", cap_dest[c], tbl[i].exp_dest);
            chk("vec_user", cap_user[c], {112'd0, tbl[i].src});
            if (tbl[i].exp_gap != 0) begin
                chk("vec_gap", cap_cyc[c] - cap_cyc[c-1], tbl[i].exp_gap);
            end
        end
    endtask

    initial begin
        int s;
        // Test 1: single 3-beat packet on q0
        tbl[0]  = '{0, 16'h0A01, 32'h11110000, 5'd31, 1'b0, 32'hFFFFFFFF, 4'd0, 0};
        tbl[1]  = '{0, 16'h0A02, 32'h11110001, 5'd31, 1'b0, 32'hFFFFFFFF, 4'd0, 1};
        tbl[2]  = '{0, 16'h0A03, 32'h11110002, 5'd3,  1'b1, 32'h0000000F, 4'd0, 1};
        // Test 2: q0/q1 two 2-beat packets each, listed in expected egress order
        tbl[3]  = '{0, 16'h0B00, 32'h22220000, 5'd31, 1'b0, 32'hFFFFFFFF, 4'd0, 0};
        tbl[4]  = '{0, 16'h0B01, 32'h22220001, 5'd0,  1'b1, 32'h00000001, 4'd0, 1};
        tbl[5]  = '{1, 16'h0B10, 32'h22221000, 5'd31, 1'b0, 32'hFFFFFFFF, 4'd1, 2};
        tbl[6]  = '{1, 16'h0B11, 32'h22221001, 5'd15, 1'b1, 32'h0000FFFF, 4'd1, 1};
        tbl[7]  = '{0, 16'h0B02, 32'h22220002, 5'd31, 1'b0, 32'hFFFFFFFF, 4'd0, 2};
        tbl[8]  = '{0, 16'h0B03, 32'h22220003, 5'd31, 1'b1, 32'hFFFFFFFF, 4'd0, 1};
        tbl[9]  = '{1, 16'h0B12, 32'h22221002, 5'd31, 1'b0, 32'hFFFFFFFF, 4'd1, 2};
        tbl[10] = '{1, 16'h0B13, 32'h22221003, 5'd30, 1'b1, 32'h7FFFFFFF, 4'd1, 1};

        reset    = 1'b1;
        enable   = 1'b0;
        m_tready = 1'b0;
        repeat (3) step();
        chk("rst_ctl", {m_tvalid, m_tlast, m_tstrb, m_tdest, m_tid, q_rd, err_short}, '0);
        chk("rst_data", m_tdata, '0);
        chk("rst_user", m_tuser, '0);
        chk("rst_cnt", {word_cnt, pkt_cnt}, '0);
        reset    = 1'b0;
        enable   = 1'b1;
        m_tready = 1'b1;
        step();

        // Test 1
        run_group(0, 2);
        chk("t1_cnt", {word_cnt, pkt_cnt}, {32'd3, 32'd1});

        // Test 2 from a fresh arbiter pointer so q0 wins first
        pulse_reset();
        run_group(3, 10);
        chk("t2_cnt", {word_cnt, pkt_cnt}, {32'd8, 32'd4});

        // Test 3: stall mid-packet
        s = cap_n;
        push(0, mk(16'h0C00, 32'h33330000, 5'd31, 1'b0));
        push(0, mk(16'h0C01, 32'h33330001, 5'd31, 1'b0));
        push(0, mk(16'h0C02, 32'h33330002, 5'd3,  1'b1));
        wait_valid();
        step();
        m_tready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("t3_hold", {m_tvalid, q_rd, m_tlast, m_tstrb, m_tdata},
                {1'b1, 4'b0000, 1'b0, 32'hFFFFFFFF, {8{32'h33330001}}});
            if (i < 5) step();
        end
        m_tready = 1'b1;
        wait_caps(s + 3);
        chk_beat("t3_b0", s,     32'h33330000, 32'hFFFFFFFF, 1'b0, 4'd0);
        chk_beat("t3_b1", s + 1, 32'h33330001, 32'hFFFFFFFF, 1'b0, 4'd0);
        chk_beat("t3_b2", s + 2, 32'h33330002, 32'h0000000F, 1'b1, 4'd0);
        step();
        chk("t3_cnt", {cap_n, word_cnt, pkt_cnt}, {32'(s + 3), 32'd11, 32'd5});

        // Test 4: q2 runs dry mid-packet while q3 waits
        s = cap_n;
        push(2, mk(16'h0D20, 32'h44442000, 5'd31, 1'b0));
        push(3, mk(16'h0D30, 32'h44443000, 5'd31, 1'b0));
        push(3, mk(16'h0D31, 32'h44443001, 5'd1,  1'b1));
        wait_caps(s + 1);
        for (int i = 0; i < 5; i++) begin
            chk("t4_dry", {m_tvalid, q_rd}, 5'b0);
            step();
        end
        chk("t4_nobeat", cap_n, s + 1);
        push(2, mk(16'h0D21, 32'h44442001, 5'd31, 1'b0));
        push(2, mk(16'h0D22, 32'h44442002, 5'd7,  1'b1));
        wait_caps(s + 5);
        chk_beat("t4_b0", s,     32'h44442000, 32'hFFFFFFFF, 1'b0, 4'd2);
        chk_beat("t4_b1", s + 1, 32'h44442001, 32'hFFFFFFFF, 1'b0, 4'd2);
        chk_beat("t4_b2", s + 2, 32'h44442002, 32'h000000FF, 1'b1, 4'd2);
        chk_beat("t4_b3", s + 3, 32'h44443000, 32'hFFFFFFFF, 1'b0, 4'd3);
        chk_beat("t4_b4", s + 4, 32'h44443001, 32'h00000003, 1'b1, 4'd3);
        chk("t4_user", cap_user[s + 3], {112'd0, 16'h0D30});
        chk("t4_cnt", {word_cnt, pkt_cnt}, {32'd16, 32'd7});

        // Test 5: reset while a q0 packet is stalled, q1 also pending
        m_tready = 1'b0;
        s = cap_n;
        push(0, mk(16'h0E00, 32'h55550000, 5'd31, 1'b0));
        push(0, mk(16'h0E01, 32'h55550001, 5'd31, 1'b0));
        push(0, mk(16'h0E02, 32'h55550002, 5'd31, 1'b1));
        push(1, mk(16'h0E10, 32'h55551000, 5'd31, 1'b0));
        push(1, mk(16'h0E11, 32'h55551001, 5'd2,  1'b1));
        wait_valid();
        reset = 1'b1;
        step();
        chk("t5_rst_ctl", {m_tvalid, m_tlast, m_tstrb, m_tdest, q_rd, err_short}, '0);
        chk("t5_rst_data", m_tdata, '0);
        chk("t5_rst_user", m_tuser, '0);
        chk("t5_rst_cnt", {word_cnt, pkt_cnt}, '0);
        reset    = 1'b0;
        m_tready = 1'b1;
        wait_caps(s + 4);
        chk_beat("t5_b0", s,     32'h55550001, 32'hFFFFFFFF, 1'b0, 4'd0);
        chk_beat("t5_b1", s + 1, 32'h55550002, 32'hFFFFFFFF, 1'b1, 4'd0);
        chk_beat("t5_b2", s + 2, 32'h55551000, 32'hFFFFFFFF, 1'b0, 4'd1);
        chk_beat("t5_b3", s + 3, 32'h55551001, 32'h00000007, 1'b1, 4'd1);
        chk("t5_cnt", {word_cnt, pkt_cnt}, {32'd4, 32'd2});

        // Test 6: short non-last beat
        chk("t6_err_pre", err_short, 1'b0);
        s = cap_n;
        push(2, mk(16'h0F20, 32'h66662000, 5'd7,  1'b0));
        push(2, mk(16'h0F21, 32'h66662001, 5'd31, 1'b1));
        wait_caps(s + 2);
        chk_beat("t6_b0", s,     32'h66662000, 32'h000000FF, 1'b0, 4'd2);
        chk_beat("t6_b1", s + 1, 32'h66662001, 32'hFFFFFFFF, 1'b1, 4'd2);
        chk("t6_err", err_short, 1'b1);
        repeat (3) step();
        chk("t6_err_sticky", {err_short, word_cnt, pkt_cnt}, {1'b1, 32'd6, 32'd3});
        pulse_reset();
        chk("t6_err_clr", err_short, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
